// File: rtl/vslc_insn_fetch.sv
// Instruction fetch front end: seeks an EEPROM byte reader, pairs bytes into
// 16-bit words and queues them in a 2-entry FIFO for the core.
module vslc_insn_fetch #(
  parameter int          SEEK_CYCLES  = 2,
  parameter logic [15:0] RESET_VECTOR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_ready,
  input  logic [7:0]  rd_byte,
  output logic        goto_address,
  output logic [15:0] address,
  output logic        hold_n,
  input  logic        jump,
  input  logic [15:0] jump_target,
  output logic        insn_valid,
  output logic [15:0] insn,
  output logic [15:0] insn_addr,
  input  logic        insn_ready,
  output logic        overflow
);

  typedef enum logic [1:0] {IDLE, SEEK, HI, LO} state_t;

  localparam int CW = (SEEK_CYCLES > 1) ? $clog2(SEEK_CYCLES) : 1;

  state_t        state;
  logic [CW-1:0] seek_cnt;
  logic          rd_ready_q;
  logic [7:0]    hi_byte;
  logic [15:0]   fetch_addr;
  logic [1:0]    count;
  logic [15:0]   q_insn [2];
  logic [15:0]   q_addr [2];

  logic          accept;
  logic          push;
  logic          pop;
  logic [15:0]   new_insn;
  logic [15:0]   jump_addr;

  // Only a fresh rising edge of rd_ready counts as a new byte.
  assign accept    = rd_ready && !rd_ready_q && (state == HI || state == LO);
  assign push      = accept && (state == LO) && (count != 2'd2);
  assign pop       = insn_valid && insn_ready;
  assign new_insn  = {hi_byte, rd_byte};
  assign jump_addr = {jump_target[15:1], 1'b0};

  assign insn_valid = (count != 2'd0);
  assign hold_n     = (count != 2'd2);
  assign insn       = q_insn[0];
  assign insn_addr  = q_addr[0];

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side below reads the value from before this clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      seek_cnt     <= '0;
      rd_ready_q   <= 1'b0;
      hi_byte      <= 8'h00;
      fetch_addr   <= RESET_VECTOR;
      address      <= RESET_VECTOR;
      goto_address <= 1'b0;
      overflow     <= 1'b0;
      count        <= 2'd0;
      // NOTE: the FIFO storage is reset too because insn/insn_addr must read
      // zero during reset; a plain data array would normally be left unreset.
      for (int i = 0; i < 2; i++) begin
        q_insn[i] <= 16'h0000;
        q_addr[i] <= 16'h0000;
      end
    end else begin
      rd_ready_q <= rd_ready;
      if (jump) begin
        // Redirect wins over any push/pop this cycle and drops a held high byte.
        count        <= 2'd0;
        hi_byte      <= 8'h00;
        fetch_addr   <= jump_addr;
        address      <= jump_addr;
        goto_address <= 1'b1;
        seek_cnt     <= '0;
        state        <= SEEK;
      end else begin
        case (state)
          IDLE: begin
            fetch_addr   <= RESET_VECTOR;
            address      <= RESET_VECTOR;
            goto_address <= 1'b1;
            seek_cnt     <= '0;
            state        <= SEEK;
          end
          SEEK: begin
            if (seek_cnt == CW'(SEEK_CYCLES - 1)) begin
              goto_address <= 1'b0;
              state        <= HI;
            end else begin
              seek_cnt <= seek_cnt + CW'(1);
            end
          end
          HI: begin
            if (accept) begin
              hi_byte <= rd_byte;
              state   <= LO;
            end
          end
          LO: begin
            if (accept) begin
              state <= HI;
              if (count == 2'd2) overflow   <= 1'b1;
              else               fetch_addr <= fetch_addr + 16'd2;
            end
          end
          default: state <= IDLE;
        endcase

        case ({push, pop})
          2'b10: begin
            q_insn[count[0]] <= new_insn;
            q_addr[count[0]] <= fetch_addr;
            count            <= count + 2'd1;
          end
          2'b01: begin
            q_insn[0] <= q_insn[1];
            q_addr[0] <= q_addr[1];
            count     <= count - 2'd1;
          end
          2'b11: begin
            // Only reachable with one entry: the new word replaces the head.
            q_insn[0] <= new_insn;
            q_addr[0] <= fetch_addr;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vslc_insn_fetch.sv
// Directed bench for vslc_insn_fetch: expected words go into a scoreboard
// queue and a negedge monitor compares them as the core pops the FIFO head.
module tb_vslc_insn_fetch;

  localparam int SEEK_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_ready;
  logic [7:0]  rd_byte;
  logic        goto_address;
  logic [15:0] address;
  logic        hold_n;
  logic        jump;
  logic [15:0] jump_target;
  logic        insn_valid;
  logic [15:0] insn;
  logic [15:0] insn_addr;
  logic        insn_ready;
  logic        overflow;

  int passes = 0;
  int total  = 0;
  logic [31:0] exp_q [$];

  vslc_insn_fetch #(.SEEK_CYCLES(SEEK_CYCLES), .RESET_VECTOR(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .rd_ready(rd_ready), .rd_byte(rd_byte),
    .goto_address(goto_address), .address(address), .hold_n(hold_n),
    .jump(jump), .jump_target(jump_target), .insn_valid(insn_valid),
    .insn(insn), .insn_addr(insn_addr), .insn_ready(insn_ready),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Monitor: every head the core accepts must match the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && insn_valid && insn_ready) begin
      if (exp_q.size() == 0) check("unexpected_pop", {insn, insn_addr}, 32'hxxxxxxxx);
      else check("pop_word", {insn, insn_addr}, exp_q.pop_front());
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rd_byte  = b;
    rd_ready = 1'b1;
    @(posedge clk); #1;
    rd_ready = 1'b0;
  endtask

  task automatic wait_seek(input logic [15:0] a);
    int guard = 0;
    int n = 0;
    logic [15:0] seen = 16'h0000;
    @(negedge clk);
    while (!goto_address && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    seen = address;
    while (goto_address && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("seek_len", n, SEEK_CYCLES);
    check("seek_addr", {16'h0, seen}, {16'h0, a});
  endtask

  task automatic do_jump(input logic [15:0] t);
    @(posedge clk); #1;
    jump        = 1'b1;
    jump_target = t;
    @(posedge clk); #1;
    jump = 1'b0;
    exp_q.delete();
  endtask

  task automatic drain(input string name);
    int guard = 0;
    while (exp_q.size() != 0 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_goto"},  {31'h0, goto_address}, 32'h0);
    check({tag, "_addr"},  {16'h0, address}, 32'h0);
    check({tag, "_hold"},  {31'h0, hold_n}, 32'h1);
    check({tag, "_valid"}, {31'h0, insn_valid}, 32'h0);
    check({tag, "_insn"},  {insn, insn_addr}, 32'h0);
    check({tag, "_ovf"},   {31'h0, overflow}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rd_ready = 1'b0; rd_byte = 8'h00;
    jump = 1'b0; jump_target = 16'h0000; insn_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");

    // Power-up seek to the reset vector and first word.
    @(posedge clk); #1 rst_n = 1'b1;
    wait_seek(16'h0000);
    insn_ready = 1'b1;
    exp_q.push_back({16'h1234, 16'h0000});
    send_byte(8'h12);
    send_byte(8'h34);
    drain("drain_first");

    // Fill the queue with the core stalled, then overrun it.
    insn_ready = 1'b0;
    exp_q.push_back({16'hA1A2, 16'h0002});
    exp_q.push_back({16'hB1B2, 16'h0004});
    send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hB1); send_byte(8'hB2);
    @(negedge clk);
    check("full_hold", {31'h0, hold_n}, 32'h0);
    check("full_valid", {31'h0, insn_valid}, 32'h1);
    send_byte(8'hC1);
    @(negedge clk);
    check("fifth_head", {insn, insn_addr}, {16'hA1A2, 16'h0002});
    check("fifth_ovf", {31'h0, overflow}, 32'h0);
    send_byte(8'hC2);
    @(negedge clk);
    check("sixth_ovf", {31'h0, overflow}, 32'h1);
    check("sixth_hold", {31'h0, hold_n}, 32'h0);
    insn_ready = 1'b1;
    drain("drain_full");

    // One word queued, then push and pop on the same edge.
    insn_ready = 1'b0;
    exp_q.push_back({16'hD1D2, 16'h0006});
    exp_q.push_back({16'hE1E2, 16'h0008});
    send_byte(8'hD1); send_byte(8'hD2); send_byte(8'hE1);
    @(posedge clk); #1;
    rd_byte = 8'hE2; rd_ready = 1'b1; insn_ready = 1'b1;
    @(posedge clk); #1;
    rd_ready = 1'b0; insn_ready = 1'b0;
    @(negedge clk);
    check("pushpop_valid", {31'h0, insn_valid}, 32'h1);
    check("pushpop_hold", {31'h0, hold_n}, 32'h1);
    check("pushpop_head", {insn, insn_addr}, {16'hE1E2, 16'h0008});

    // Jump with a word queued and a high byte held.
    send_byte(8'hF1);
    do_jump(16'h0103);
    wait_seek(16'h0102);
    check("jump_flush", {31'h0, insn_valid}, 32'h0);
    insn_ready = 1'b1;
    exp_q.push_back({16'h5678, 16'h0102});
    send_byte(8'h56); send_byte(8'h78);
    drain("drain_jump");

    // Address wrap at the top of memory.
    do_jump(16'hFFFE);
    wait_seek(16'hFFFE);
    exp_q.push_back({16'h9ABC, 16'hFFFE});
    exp_q.push_back({16'hDEF0, 16'h0000});
    send_byte(8'h9A); send_byte(8'hBC); send_byte(8'hDE); send_byte(8'hF0);
    drain("drain_wrap");
    check("ovf_sticky", {31'h0, overflow}, 32'h1);

    // Reset between the two bytes of a word.
    send_byte(8'h11);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1 check_reset_outputs("midreset");
    @(posedge clk); #1 rst_n = 1'b1;
    wait_seek(16'h0000);
    exp_q.push_back({16'h2233, 16'h0000});
    send_byte(8'h22); send_byte(8'h33);
    drain("drain_reset");

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/vslc_insn_fetch.md
VSLC_INSN_FETCH -- requirements
Module: vslc_insn_fetch

Interface
REQ-001 SHALL have parameter SEEK_CYCLES, default 2, number of cycles goto_address is held high per seek.
REQ-002 SHALL have parameter RESET_VECTOR, default 16'h0000, the byte address fetched after reset.
REQ-003 SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have the port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have the port rd_ready, input, 1 bit: byte-available level from the EEPROM reader.
REQ-006 SHALL have the port rd_byte, input, 8 bits: byte from the reader, valid while rd_ready is high.
REQ-007 SHALL have the port goto_address, output, 1 bit: seek request to the reader.
REQ-008 SHALL have the port address, output, 16 bits: seek byte address to the reader.
REQ-009 SHALL have the port hold_n, output, 1 bit: low pauses the reader.
REQ-010 SHALL have the port jump, input, 1 bit: one-cycle redirect request from the core.
REQ-011 SHALL have the port jump_target, input, 16 bits: redirect byte address.
REQ-012 SHALL have the port insn_valid, output, 1 bit: queue head is valid.
REQ-013 SHALL have the port insn, output, 16 bits: queue head instruction word.
REQ-014 SHALL have the port insn_addr, output, 16 bits: byte address of the high byte of insn.
REQ-015 SHALL have the port insn_ready, input, 1 bit: core accepts the head.
REQ-016 SHALL have the port overflow, output, 1 bit: sticky flag set when a byte is dropped.

Function
REQ-017 A byte SHALL be accepted on a cycle where rd_ready=1 and the registered rd_ready of the previous cycle was 0 (rising-edge detect), and only in state HI or LO.
REQ-018 States SHALL be IDLE, SEEK, HI and LO.
REQ-019 IDLE SHALL go to SEEK unconditionally on the next cycle, with seek target RESET_VECTOR.
REQ-020 In SEEK, goto_address SHALL be 1 for exactly SEEK_CYCLES cycles with address=target, then the state SHALL go to HI; rd_ready edges in SEEK SHALL be ignored.
REQ-021 HI: an accepted byte SHALL be stored as bits [15:8] and the state SHALL go to LO.
REQ-022 LO: an accepted byte SHALL form {hi,byte}, be pushed with fetch_addr as insn_addr, then fetch_addr SHALL be incremented by 2 (wrapping 16'hFFFE->16'h0000) and the state SHALL go to HI.
REQ-023 The queue SHALL be a 2-entry FIFO of {insn, insn_addr}; insn_valid=(count!=0).
REQ-024 A pop SHALL occur when insn_valid and insn_ready are both 1.
REQ-025 A simultaneous push and pop SHALL leave count unchanged, preserving order.
REQ-026 hold_n SHALL be 0 when count==2, else 1 (combinational).
REQ-027 A byte accepted when count==2 and the state is LO SHALL be dropped, overflow SHALL be set to 1 (sticky until reset), and the state SHALL go to HI.
REQ-028 jump=1 SHALL, on the same edge, flush the queue (count=0), discard any held high byte, set target=fetch_addr={jump_target[15:1],1'b0}, and enter SEEK with the pulse counter restarted.
REQ-029 Jump SHALL take priority over a simultaneous push or pop; neither SHALL take effect.
REQ-030 A jump during SEEK SHALL restart the pulse with the new target.
REQ-031 Jump-to-first-insn_valid latency SHALL be SEEK_CYCLES + 2 byte acceptances + 1 cycle.

Reset
REQ-032 While rst_n=0, state SHALL be IDLE, goto_address=0, address=RESET_VECTOR, hold_n=1, insn_valid=0, insn=0, insn_addr=0, overflow=0, fetch_addr=RESET_VECTOR, and count=0.
REQ-033 Reset asserted mid-word or mid-seek SHALL discard all partial state, and after release the block SHALL proceed from IDLE per REQ-019.

Verification
REQ-034 Release reset, feed bytes 0x12,0x34 -> goto_address high 2 cycles with address=0x0000, then insn_valid=1, insn=0x1234, insn_addr=0x0000.
REQ-035 Feed 6 bytes with insn_ready=0 -> 2 words queued, hold_n=0 after the 4th byte, the 5th byte (with no 6th accepted) leaves queue unchanged; the 6th byte sets overflow=1.
REQ-036 Queue holds 1 word, pop and push on the same cycle -> count stays 1, the new word is at the head next cycle.
REQ-037 jump=1, jump_target=0x0103 while 1 word is queued and a high byte is held -> queue empty, address=0x0102, goto pulse of 2 cycles, next word insn_addr=0x0102.
REQ-038 Jump to 0xFFFE, feed 4 bytes -> insn_addr 0xFFFE then 0x0000.
REQ-039 Assert rst_n=0 between the two bytes of a word -> all outputs at reset values immediately, and after release a new seek to 0x0000.
